// File: rtl/mem_system_pkg.sv
// ============================================================================
// Module      : mem_system_pkg
// Description : Shared constants and types for the memory access master:
//               region base addresses, FSM state encoding and status codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_system_pkg;

    localparam logic [31:0] RAM_BASE = 32'h1001_0000;
    localparam logic [31:0] ROM_BASE = 32'h0040_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_MISALIGN  = 2'b01;
    localparam logic [1:0] ERR_UNMAPPED  = 2'b10;
    localparam logic [1:0] ERR_ROM_WRITE = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mem_addr_decoder.sv
// ============================================================================
// Module      : mem_addr_decoder
// Description : Combinational MIPS memory-map decoder. Flags RAM/ROM hits and
//               classifies the access as OK, misaligned, unmapped or ROM store.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_addr_decoder #(
    parameter int                     DATA_WIDTH   = 32,
    parameter int                     MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0]  RAM_BASE     = mem_system_pkg::RAM_BASE,
    parameter logic [DATA_WIDTH-1:0]  ROM_BASE     = mem_system_pkg::ROM_BASE
) (
    input  logic [DATA_WIDTH-1:0] address,
    input  logic                  write,
    output logic                  is_ram,
    output logic                  is_rom,
    output logic [1:0]            error
);
    import mem_system_pkg::*;

    // One extra bit keeps BASE + span from wrapping at the top of the map.
    localparam int              EW     = DATA_WIDTH + 1;
    localparam logic [EW-1:0]   SPAN   = EW'(MEMORY_DEPTH * 4);
    localparam logic [EW-1:0]   RAM_LO = {1'b0, RAM_BASE};
    localparam logic [EW-1:0]   RAM_HI = RAM_LO + SPAN;
    localparam logic [EW-1:0]   ROM_LO = {1'b0, ROM_BASE};
    localparam logic [EW-1:0]   ROM_HI = ROM_LO + SPAN;

    logic [EW-1:0] addr_ext;
    assign addr_ext = {1'b0, address};

    // Region match and prioritised error classification.
    always_comb begin
        is_ram = (addr_ext >= RAM_LO) && (addr_ext < RAM_HI);
        is_rom = (addr_ext >= ROM_LO) && (addr_ext < ROM_HI);
        error  = ERR_NONE;
        if (address[1:0] != 2'b00) begin
            error = ERR_MISALIGN;
        end else if (!is_ram && !is_rom) begin
            error = ERR_UNMAPPED;
        end else if (is_rom && write) begin
            error = ERR_ROM_WRITE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_master.sv
// ============================================================================
// Module      : mem_access_master
// Description : Single-outstanding load/store initiator for the memory system.
//               Decodes the request, drives one write cycle or a fixed-latency
//               read, and returns data/status on a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_master #(
    parameter int                     DATA_WIDTH   = 32,
    parameter int                     MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0]  RAM_BASE     = mem_system_pkg::RAM_BASE,
    parameter logic [DATA_WIDTH-1:0]  ROM_BASE     = mem_system_pkg::ROM_BASE,
    parameter int                     READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_address_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [1:0]            rsp_error_o,
    output logic                  mem_write_enable_o,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    input  logic [DATA_WIDTH-1:0] mem_read_data_i
);
    import mem_system_pkg::*;

    // Counter reaches 0 in the last READ cycle, when read data is valid.
    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] lat_cnt;
    logic       dec_is_ram;
    logic       dec_is_rom;
    logic [1:0] dec_error;
    logic       legal;

    mem_addr_decoder #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .RAM_BASE     (RAM_BASE),
        .ROM_BASE     (ROM_BASE)
    ) u_decoder (
        .address (req_address_i),
        .write   (req_write_i),
        .is_ram  (dec_is_ram),
        .is_rom  (dec_is_rom),
        .error   (dec_error)
    );

    assign legal = (dec_error == ERR_NONE) && (dec_is_ram || dec_is_rom);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived handshake/strobe outputs.
    always_comb begin
        state_next         = state;
        req_ready_o        = 1'b0;
        rsp_valid_o        = 1'b0;
        mem_write_enable_o = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (!legal)           state_next = ST_RESP;
                    else if (req_write_i) state_next = ST_WRITE;
                    else                  state_next = ST_READ;
                end
            end
            ST_WRITE: begin
                mem_write_enable_o = 1'b1;
                state_next         = ST_RESP;
            end
            ST_READ: begin
                if (lat_cnt == 2'd0) state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture, latency count, read-data capture and response clear.
    // Memory-side address/data only move for legal requests so an error never
    // disturbs the memory bus.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_cnt          <= 2'd0;
            mem_address_o    <= '0;
            mem_write_data_o <= '0;
            rsp_rdata_o      <= '0;
            rsp_error_o      <= ERR_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        rsp_error_o <= dec_error;
                        lat_cnt     <= LAT_INIT;
                        if (legal) begin
                            mem_address_o    <= req_address_i;
                            mem_write_data_o <= req_wdata_i;
                        end
                    end
                end
                ST_READ: begin
                    if (lat_cnt == 2'd0) begin
                        rsp_rdata_o <= mem_read_data_i;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_rdata_o <= '0;
                        rsp_error_o <= ERR_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_master.sv
// ============================================================================
// Module      : tb_mem_access_master
// Description : Self-checking bench for mem_access_master with a simple
//               attached memory and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_master;

    localparam int          RL   = 1;
    localparam logic [31:0] RAMB = 32'h1001_0000;
    localparam logic [31:0] ROMB = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_address = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_error;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_master #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (32),
        .RAM_BASE     (RAMB),
        .ROM_BASE     (ROMB),
        .READ_LATENCY (RL)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_write_i        (req_write),
        .req_address_i      (req_address),
        .req_wdata_i        (req_wdata),
        .rsp_valid_o        (rsp_valid),
        .rsp_ready_i        (rsp_ready),
        .rsp_rdata_o        (rsp_rdata),
        .rsp_error_o        (rsp_error),
        .mem_write_enable_o (mem_we),
        .mem_address_o      (mem_address),
        .mem_write_data_o   (mem_wdata),
        .mem_read_data_i    (mem_rdata)
    );

    function automatic logic [31:0] rom_word(input int i);
        return 32'h0BAD_0000 ^ (32'(i) * 32'h0001_1011);
    endfunction

    // Attached memory: asynchronous read, write on the clock edge.
    logic [31:0] ram_mem [32];
    logic [31:0] rom_mem [32];

    always_comb begin
        mem_rdata = 32'hDEAD_BEEF;
        if (mem_address >= RAMB && mem_address < RAMB + 32'd128)
            mem_rdata = ram_mem[5'((mem_address - RAMB) >> 2)];
        else if (mem_address >= ROMB && mem_address < ROMB + 32'd128)
            mem_rdata = rom_mem[5'((mem_address - ROMB) >> 2)];
    end

    always @(posedge clk) begin
        if (mem_we && mem_address >= RAMB && mem_address < RAMB + 32'd128)
            ram_mem[5'((mem_address - RAMB) >> 2)] <= mem_wdata;
    end

    // Reference model state: what RAM should contain.
    logic [31:0] ref_ram [32];

    function automatic void predict(input logic wr, input logic [31:0] a,
                                    output logic [1:0] err, output logic [31:0] rd);
        longint la     = longint'(a);
        bit     in_ram = (la >= longint'(RAMB)) && (la < longint'(RAMB) + 128);
        bit     in_rom = (la >= longint'(ROMB)) && (la < longint'(ROMB) + 128);
        rd = 32'd0;
        if (la % 4 != 0)            err = 2'd1;
        else if (!in_ram && !in_rom) err = 2'd2;
        else if (in_rom && wr)       err = 2'd3;
        else begin
            err = 2'd0;
            if (!wr) rd = in_ram ? ref_ram[int'((la - longint'(RAMB)) / 4)]
                                 : rom_word(int'((la - longint'(ROMB)) / 4));
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_address, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    // One complete transaction with all protocol checks against the model.
    task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input int stall, output logic [1:0] err_o, output logic [31:0] rd_o);
        logic [1:0]  exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          lat;
        int          wecnt;
        predict(wr, a, exp_err, exp_rd);
        exp_lat = (exp_err != 2'd0) ? 1 : (wr ? 2 : RL + 1);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_address = a; req_wdata = d;
        rsp_ready = (stall == 0);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; wecnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_we) begin
                wecnt++;
                chk("we_addr", mem_address, a);
                chk("we_data", mem_wdata, d);
            end
            if (!rsp_valid) begin
                chk("req_ready_busy", 32'(req_ready), 32'd0);
                if (!wr) chk("rd_addr", mem_address, a);
            end
        end while (!rsp_valid && lat < 20);
        chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_error", 32'(rsp_error), 32'(exp_err));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("we_pulses", 32'(wecnt), (wr && exp_err == 2'd0) ? 32'd1 : 32'd0);
        err_o = rsp_error;
        rd_o  = rsp_rdata;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_err", 32'(rsp_error), 32'(exp_err));
            chk("stall_rdata", rsp_rdata, exp_rd);
            chk("stall_we", 32'(mem_we), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("done_valid", 32'(rsp_valid), 32'd0);
        chk("done_err", 32'(rsp_error), 32'd0);
        chk("done_rdata", rsp_rdata, 32'd0);
        chk("done_ready", 32'(req_ready), 32'd1);
        if (wr && exp_err == 2'd0) ref_ram[int'((a - RAMB) >> 2)] = d;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  e;
        logic [31:0] r;
        logic [5:0]  we_pat, rdy_pat, vld_pat;

        for (int i = 0; i < 32; i++) begin
            ram_mem[i] = 32'd0;
            ref_ram[i] = 32'd0;
            rom_mem[i] = rom_word(i);
        end

        vecs[0]  = '{1'b1, 32'h1001_0008, 32'h1234_5678, 2'd0, 32'h0};
        vecs[1]  = '{1'b0, 32'h1001_0008, 32'h0,         2'd0, 32'h1234_5678};
        for (int i = 0; i < 8; i++)
            vecs[2+i] = '{1'b0, ROMB + 32'(4*i), 32'h0, 2'd0, rom_word(i)};
        vecs[10] = '{1'b1, 32'h0040_0004, 32'hAAAA_5555, 2'd3, 32'h0};
        vecs[11] = '{1'b0, 32'h1001_0002, 32'h0,         2'd1, 32'h0};
        vecs[12] = '{1'b0, 32'h1001_0080, 32'h0,         2'd2, 32'h0};
        vecs[13] = '{1'b0, 32'h0000_0000, 32'h0,         2'd2, 32'h0};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, e, r);
            chk("vec_err", 32'(e), 32'(vecs[i].exp_err));
            chk("vec_rdata", r, vecs[i].exp_rdata);
        end

        // Backpressure: response held for 5 cycles.
        run_txn(1'b1, 32'h1001_000C, 32'hCAFE_F00D, 0, e, r);
        run_txn(1'b0, 32'h1001_000C, 32'h0, 5, e, r);
        chk("bp_rdata", r, 32'hCAFE_F00D);

        // Back-to-back stores with req_valid held: accept only in IDLE.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1;
        req_address = 32'h1001_0014; req_wdata = 32'h0F0F_0F0F; rsp_ready = 1'b1;
        @(posedge clk);
        we_pat = '0; rdy_pat = '0; vld_pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            we_pat[i] = mem_we; rdy_pat[i] = req_ready; vld_pat[i] = rsp_valid;
        end
        req_valid = 1'b0;
        chk("b2b_we", 32'(we_pat), 32'b001001);
        chk("b2b_ready", 32'(rdy_pat), 32'b100100);
        chk("b2b_valid", 32'(vld_pat), 32'b010010);
        ref_ram[5] = 32'h0F0F_0F0F;
        @(negedge clk);
        chk("b2b_idle", 32'(req_ready), 32'd1);
        run_txn(1'b0, 32'h1001_0014, 32'h0, 0, e, r);

        // Reset asserted during the WRITE cycle of a store.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1;
        req_address = 32'h1001_0010; req_wdata = 32'h55AA_55AA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_we_before", 32'(mem_we), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("rst_mid");
        reset = 1'b1;
        ref_ram[4] = 32'h55AA_55AA;
        @(negedge clk);
        chk("rst_release_ready", 32'(req_ready), 32'd1);
        chk("rst_release_valid", 32'(rsp_valid), 32'd0);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            int          region;
            logic [31:0] a;
            region = $urandom_range(0, 2);
            a = (region == 0) ? RAMB : (region == 1) ? ROMB : $urandom;
            if (region != 2) a = a + 32'($urandom_range(0, 35)) * 32'd4;
            if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
            run_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2), e, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_master.md
# mem_access_master

Initiator-side controller for `memory_system_wrapper`. Accepts single load/store requests from a core-side valid/ready port and drives the memory system's write-enable, address and write-data inputs. Captures the returned read data after a fixed latency and returns it on a valid/ready response port. Decodes the MIPS memory map (data RAM at `0x1001_0000`, program ROM at `0x0040_0000`) and rejects illegal accesses without touching memory.

## Interface
- `DATA_WIDTH`, 32: width of address, write data and read data.
- `MEMORY_DEPTH`, 32: words per region; each region spans `MEMORY_DEPTH*4` bytes.
- `RAM_BASE`, `32'h1001_0000`: byte base address of the data RAM.
- `ROM_BASE`, `32'h0040_0000`: byte base address of the program ROM.
- `READ_LATENCY`, 1: cycles from address presentation to valid `mem_read_data_i`. Legal range is 1..4.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: controller can accept a request.
- `req_write_i`, in, 1: 1 = store, 0 = load.
- `req_address_i`, in, DATA_WIDTH: byte address.
- `req_wdata_i`, in, DATA_WIDTH: store data.
- `rsp_valid_o`, out, 1: response valid.
- `rsp_ready_i`, in, 1: consumer accepts the response.
- `rsp_rdata_o`, out, DATA_WIDTH: load data. It is 0 for stores and errors.
- `rsp_error_o`, out, 2: status code. `00` OK, `01` misaligned, `10` unmapped, `11` write to ROM.
- `mem_write_enable_o`, out, 1: connects to `while_enable_i` of the memory system.
- `mem_address_o`, out, DATA_WIDTH: connects to `address_i`.
- `mem_write_data_o`, out, DATA_WIDTH: connects to `write_data`.
- `mem_read_data_i`, in, DATA_WIDTH: connects from `instruction_o`.

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- **IDLE**
  - `req_ready_o` = 1.
  - On `req_valid_i & req_ready_o`, the controller latches `write`, `address` and `wdata`, then decodes.
  - Error → RESP. Store → WRITE. Load → READ, with the latency counter loaded to `READ_LATENCY-1`.
- **Decode priority:** misaligned (`address[1:0] != 0`) > unmapped (not in `[BASE, BASE+MEMORY_DEPTH*4)` of either region) > store to ROM.
- **Error requests** produce no memory activity.
- **WRITE** lasts exactly 1 cycle.
  - `mem_write_enable_o` = 1, with `mem_address_o` and `mem_write_data_o` = latched values.
  - Next state RESP with status `00`.
- **READ**
  - `mem_address_o` = latched address; `mem_write_enable_o` = 0.
  - The counter decrements each cycle.
  - In the cycle the counter reads 0, `mem_read_data_i` is registered into `rsp_rdata_o` and the FSM moves to RESP.
- **RESP**
  - `rsp_valid_o` = 1. `rsp_rdata_o` and `rsp_error_o` are held stable until `rsp_ready_i`.
  - On `rsp_valid_o & rsp_ready_i` → IDLE, and `rsp_rdata_o` and `rsp_error_o` clear to 0.
- `req_ready_o` = 0 in every state except IDLE. Requests presented then are not accepted and must be held by the requester.
- `mem_address_o` and `mem_write_data_o` hold their last value in IDLE and RESP. `mem_write_enable_o` is 1 only in WRITE.
- Address range comparison uses DATA_WIDTH+1 bits, so `BASE + MEMORY_DEPTH*4` cannot wrap.

## Timing
- **Reset values:** state IDLE, `req_ready_o` 1, `rsp_valid_o` 0, `rsp_rdata_o` 0, `rsp_error_o` 0, `mem_write_enable_o` 0, `mem_address_o` 0, `mem_write_data_o` 0, counter 0.
- **Timeline for a request accepted at edge k:**
  - Store: `mem_write_enable_o` is high in cycle k+1 only; `rsp_valid_o` from cycle k+2.
  - Load: READ occupies cycles k+1 .. k+READ_LATENCY; `rsp_valid_o` from cycle k+READ_LATENCY+1.
  - Error: `rsp_valid_o` from cycle k+1.
- **Back-to-back:** with `rsp_ready_i` held high, a store takes 3 cycles per transaction and a load takes READ_LATENCY+2. The next accept happens in the IDLE cycle after RESP.
- **Backpressure:** `rsp_ready_i` low stalls in RESP indefinitely, with outputs unchanged.
- **Reset mid-operation:** `reset` low at any edge returns to the reset values at that edge. A write in progress is aborted: `mem_write_enable_o` drops at that edge. A pending response is discarded.
- **Simultaneous events:** `req_valid_i` asserted in the same cycle that RESP completes is accepted in the following IDLE cycle, not the same cycle.

## Structure
- Shared package `mem_system_pkg` holds:
  - region base constants `RAM_BASE` and `ROM_BASE`;
  - FSM state encoding (IDLE=0, WRITE=1, READ=2, RESP=3);
  - error code constants `ERR_NONE`, `ERR_MISALIGN`, `ERR_UNMAPPED`, `ERR_ROM_WRITE`.
- Sub-module `mem_addr_decoder` is combinational:
  - inputs: address, write flag;
  - outputs: `is_ram`, `is_rom`, 2-bit error code;
  - parameterized by `MEMORY_DEPTH`, `RAM_BASE`, `ROM_BASE`.
- The decoder is instantiated once on the request inputs and used at acceptance. The controller itself holds the FSM, latency counter and registers.

## Test plan
All scenarios run with default parameters (`READ_LATENCY`=1, `MEMORY_DEPTH`=32), wired to `memory_system_wrapper`, `rsp_ready_i`=1.
- **RAM store/load:** store `0x12345678` to `0x10010008`, then load `0x10010008` → the store has `mem_write_enable_o` high for exactly 1 cycle; the load returns `rsp_rdata_o`=`0x12345678`, `rsp_error_o`=`00`, with `rsp_valid_o` 2 cycles after the load is accepted.
- **ROM load sweep:** loads from `0x400000` to `0x40001C` → each returns the preloaded ROM word with status `00`; `mem_write_enable_o` stays 0 throughout.
- **Error cases:**
  - store to `0x400004` → `rsp_error_o`=`11`, `mem_write_enable_o` never asserted, response 1 cycle after accept;
  - load `0x10010002` → `01`;
  - load `0x10010080` → `10`, since it lies past 32 words.
- **Backpressure:** load `0x1001000C` with `rsp_ready_i`=0 for 5 cycles → `rsp_valid_o` held with stable data, `req_ready_o`=0 throughout; completion follows one cycle after `rsp_ready_i` rises.
- **Reset mid-write:** pull `reset` low in the WRITE cycle of a store to `0x10010010` → `mem_write_enable_o`=0 and all outputs at reset values after that edge; `req_ready_o`=1 once reset is released.
